// File: rtl/mips_rf_pkg.sv
// Shared types for the multiport register file: read-mode selector and
// init/operate state encoding.
package mips_rf_pkg;

    typedef enum logic [1:0] {
        ASYNC  = 2'd0,
        WFIRST = 2'd1,
        RFIRST = 2'd2
    } rf_mode_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

endpackage

// File: rtl/mips_rf_scoreboard.sv
// Per-register pending bits: set when an instruction reserves its destination,
// cleared when the result is written back; exported per read port as busy.
module mips_rf_scoreboard #(
    parameter int AWL = 5,
    parameter int NRP = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               wen_i,
    input  logic [AWL-1:0]     wa_i,
    input  logic               rsv_en_i,
    input  logic [AWL-1:0]     rsv_addr_i,
    input  logic               fwd_en_i,
    input  logic [NRP*AWL-1:0] ra_i,
    output logic [NRP-1:0]     busy_o
);

    localparam int DEPTH = 1 << AWL;

    logic [DEPTH-1:0] pend_q, pend_d;

    // Reservation is applied after the write-back clear so set wins on collision.
    always_comb begin
        pend_d = pend_q;
        if (en_i) begin
            if (wen_i && (wa_i != '0)) begin
                pend_d[wa_i] = 1'b0;
            end
            if (rsv_en_i && (rsv_addr_i != '0)) begin
                pend_d[rsv_addr_i] = 1'b1;
            end
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    for (genvar i = 0; i < NRP; i++) begin : g_busy
        logic [AWL-1:0] ra;
        logic           fwd_hit;
        assign ra      = ra_i[i*AWL +: AWL];
        // A same-cycle forwarded write already satisfies the reader.
        assign fwd_hit = fwd_en_i && wen_i && (wa_i == ra);
        assign busy_o[i] = en_i && (ra != '0) && pend_q[ra] && !fwd_hit;
    end

endmodule

// File: rtl/mips_multiport_regfile.sv
// MIPS-style register file: one write port, NRP read ports, self-clearing
// after reset, with a destination-reservation scoreboard.
module mips_multiport_regfile
    import mips_rf_pkg::*;
#(
    parameter int AWL    = 5,
    parameter int DWL    = 32,
    parameter int NRP    = 2,
    parameter int MODE   = 0,
    parameter int BYPASS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wen,
    input  logic [AWL-1:0]     WA,
    input  logic [DWL-1:0]     WD,
    input  logic [NRP*AWL-1:0] RA,
    output logic [NRP*DWL-1:0] RD,
    input  logic               rsv_en,
    input  logic [AWL-1:0]     rsv_addr,
    output logic [NRP-1:0]     busy,
    output logic               ready,
    output rf_state_t          dbg_state_o
);

    localparam int             DEPTH = 1 << AWL;
    localparam logic [AWL-1:0] LAST  = {AWL{1'b1}};
    localparam rf_mode_t       RMODE = rf_mode_t'(MODE[1:0]);

    rf_state_t      state_q, state_d;
    logic [AWL-1:0] clr_ptr_q, clr_ptr_d;
    logic [DWL-1:0] mem_q [DEPTH];

    logic           wr_fire;
    logic           mem_we;
    logic [AWL-1:0] mem_wa;
    logic [DWL-1:0] mem_wd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= AWL'(1);
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST) begin
                    state_d = READY;
                end
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    assign wr_fire = (state_q == READY) && wen && (WA != '0);

    // The clear sweep owns the write port until READY; entry 0 is never stored.
    always_comb begin
        ready       = (state_q == READY);
        dbg_state_o = state_q;
        mem_we      = 1'b0;
        mem_wa      = clr_ptr_q;
        mem_wd      = '0;
        if (state_q == CLEAR) begin
            mem_we = 1'b1;
        end else if (wr_fire) begin
            mem_we = 1'b1;
            mem_wa = WA;
            mem_wd = WD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    for (genvar i = 0; i < NRP; i++) begin : g_rd
        logic [AWL-1:0] ra;
        logic [DWL-1:0] stored;
        logic           hit;
        assign ra     = RA[i*AWL +: AWL];
        assign stored = (ra == '0) ? '0 : mem_q[ra];
        assign hit    = wr_fire && (WA == ra);

        if (RMODE == ASYNC) begin : g_async
            assign RD[i*DWL +: DWL] = ((BYPASS != 0) && hit) ? WD : stored;
        end else begin : g_sync
            logic [DWL-1:0] rd_q, rd_d;
            always_comb begin
                rd_d = stored;
                if ((RMODE == WFIRST) && hit) begin
                    rd_d = WD;
                end
            end
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= rd_d;
                end
            end
            assign RD[i*DWL +: DWL] = rd_q;
        end
    end

    mips_rf_scoreboard #(
        .AWL (AWL),
        .NRP (NRP)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (state_q == READY),
        .wen_i      (wen),
        .wa_i       (WA),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .fwd_en_i   ((RMODE == ASYNC) && (BYPASS != 0)),
        .ra_i       (RA),
        .busy_o     (busy)
    );

endmodule

// File: tb/tb_mips_multiport_regfile.sv
// Bench for the register file: three instances (async+bypass, write-first,
// read-first) share stimulus and are checked against an array-based model.
module tb_mips_multiport_regfile;
    import mips_rf_pkg::*;

    localparam int AWL   = 5;
    localparam int DWL   = 32;
    localparam int NRP   = 3;
    localparam int DEPTH = 1 << AWL;

    logic               clk;
    logic               rst_n;
    logic               wen;
    logic [AWL-1:0]     wa;
    logic [DWL-1:0]     wd;
    logic [NRP*AWL-1:0] ra_bus;
    logic               rsv_en;
    logic [AWL-1:0]     rsv_addr;

    logic [NRP*DWL-1:0] rd0, rd1, rd2;
    logic [NRP-1:0]     busy0, busy1, busy2;
    logic               ready0, ready1, ready2;
    rf_state_t          st0, st1, st2;

    int checks = 0;
    int errors = 0;

    logic [DWL-1:0] m_mem [DEPTH];
    bit             m_pend [DEPTH];
    bit             m_ready;
    int             m_left;

    mips_multiport_regfile #(.AWL(AWL), .DWL(DWL), .NRP(NRP), .MODE(0), .BYPASS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .WA(wa), .WD(wd), .RA(ra_bus), .RD(rd0),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy0), .ready(ready0), .dbg_state_o(st0));

    mips_multiport_regfile #(.AWL(AWL), .DWL(DWL), .NRP(NRP), .MODE(1), .BYPASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .WA(wa), .WD(wd), .RA(ra_bus), .RD(rd1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy1), .ready(ready1), .dbg_state_o(st1));

    mips_multiport_regfile #(.AWL(AWL), .DWL(DWL), .NRP(NRP), .MODE(2), .BYPASS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .WA(wa), .WD(wd), .RA(ra_bus), .RD(rd2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy2), .ready(ready2), .dbg_state_o(st2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int get_ra(input int i);
        return int'(ra_bus[i*AWL +: AWL]);
    endfunction

    function automatic logic [DWL-1:0] sl(input logic [NRP*DWL-1:0] bus, input int i);
        return bus[i*DWL +: DWL];
    endfunction

    task automatic chk(input string tag, input logic [DWL-1:0] obs, input logic [DWL-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ra(input int a0, input int a1, input int a2);
        ra_bus = {AWL'(a2), AWL'(a1), AWL'(a0)};
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_left  = DEPTH - 1;
        for (int k = 0; k < DEPTH; k++) begin
            m_mem[k]  = '0;
            m_pend[k] = 1'b0;
        end
    endtask

    // Combinational outputs against the model for the inputs now applied.
    task automatic check_comb();
        int             a;
        logic [DWL-1:0] e;
        bit             b_fwd, b_plain;
        #1;
        for (int i = 0; i < NRP; i++) begin
            a       = get_ra(i);
            b_fwd   = 1'b0;
            b_plain = 1'b0;
            if (m_ready) begin
                if (a == 0)                            e = '0;
                else if (wen && (int'(wa) == a))       e = wd;
                else                                   e = m_mem[a];
                chk("rd_async", sl(rd0, i), e);
                b_plain = (a != 0) && m_pend[a];
                b_fwd   = b_plain && !(wen && (int'(wa) == a));
            end
            chk("busy_m0", 32'(busy0[i]), 32'(b_fwd));
            chk("busy_m1", 32'(busy1[i]), 32'(b_plain));
            chk("busy_m2", 32'(busy2[i]), 32'(b_plain));
        end
        chk("ready_m0", 32'(ready0), 32'(m_ready));
        chk("ready_m1", 32'(ready1), 32'(m_ready));
        chk("ready_m2", 32'(ready2), 32'(m_ready));
        chk("state_m0", 32'(st0), 32'(m_ready ? READY : CLEAR));
    endtask

    // One clock: check comb, advance model across the edge, check registered reads.
    task automatic tick();
        logic [DWL-1:0] e1 [NRP];
        logic [DWL-1:0] e2 [NRP];
        int             a;
        bit             valid;
        check_comb();
        @(posedge clk);
        valid = !rst_n || m_ready;
        for (int i = 0; i < NRP; i++) begin
            a = get_ra(i);
            if (!rst_n || a == 0) begin
                e1[i] = '0;
                e2[i] = '0;
            end else begin
                e2[i] = m_mem[a];
                e1[i] = (m_ready && wen && int'(wa) == a) ? wd : m_mem[a];
            end
        end
        if (!rst_n) begin
            model_reset();
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) m_ready = 1'b1;
        end else begin
            if (wen && wa != '0) begin
                m_mem[wa]  = wd;
                m_pend[wa] = 1'b0;
            end
            if (rsv_en && rsv_addr != '0) m_pend[rsv_addr] = 1'b1;
        end
        #1;
        if (valid) begin
            for (int i = 0; i < NRP; i++) begin
                chk("rd_wfirst", sl(rd1, i), e1[i]);
                chk("rd_rfirst", sl(rd2, i), e2[i]);
            end
        end
    endtask

    task automatic idle();
        wen      = 1'b0;
        rsv_en   = 1'b0;
        wa       = '0;
        wd       = '0;
        rsv_addr = '0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready0 !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        idle();
        ra_bus = '0;
        model_reset();

        // Clear and fill: one-cycle reset pulse, then 31 clearing cycles.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready(n);
        chk("clear_len", 32'(n), 32'd31);
        for (int a = 0; a < DEPTH; a++) begin
            set_ra(a, a, a);
            #1;
            chk("clear_rd_async", sl(rd0, 2), '0);
            tick();
            chk("clear_rd_sync", sl(rd2, 1), '0);
        end

        // Async bypass on write to 7.
        wen = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF; set_ra(7, 0, 0);
        #1;
        chk("bypass_same_cycle", sl(rd0, 0), 32'hDEADBEEF);
        tick();
        idle(); set_ra(0, 7, 0);
        #1;
        chk("bypass_next_cycle", sl(rd0, 1), 32'hDEADBEEF);
        tick();

        // Write to register zero is discarded.
        wen = 1'b1; wa = '0; wd = 32'h12345678; set_ra(0, 0, 0);
        tick();
        idle();
        #1;
        for (int i = 0; i < NRP; i++) begin
            chk("zero_async", sl(rd0, i), '0);
            chk("zero_wfirst", sl(rd1, i), '0);
            chk("zero_rfirst", sl(rd2, i), '0);
        end
        tick();

        // Write-first versus read-first collision on entry 5.
        wen = 1'b1; wa = 5'd5; wd = 32'h11;
        tick();
        wd = 32'h22; set_ra(5, 1, 2);
        tick();
        chk("collide_wfirst", sl(rd1, 0), 32'h22);
        chk("collide_rfirst", sl(rd2, 0), 32'h11);
        idle();

        // Reservation / write-back on register 9.
        rsv_en = 1'b1; rsv_addr = 5'd9; set_ra(0, 0, 9);
        tick();
        idle();
        #1;
        chk("rsv_busy", 32'(busy1[2]), 32'd1);
        wen = 1'b1; wa = 5'd9; wd = 32'h99; rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        idle();
        #1;
        chk("set_wins_m1", 32'(busy1[2]), 32'd1);
        chk("set_wins_m0", 32'(busy0[2]), 32'd1);
        wen = 1'b1; wa = 5'd9; wd = 32'h9A;
        #1;
        chk("busy_fwd_m0", 32'(busy0[2]), 32'd0);
        chk("busy_nofwd_m1", 32'(busy1[2]), 32'd1);
        tick();
        idle();
        #1;
        chk("busy_cleared", 32'(busy1[2]), 32'd0);

        // Randomised traffic with biased address collisions.
        for (int t = 0; t < 300; t++) begin
            wen      = 1'($urandom_range(0, 1));
            wa       = AWL'($urandom_range(0, 7));
            wd       = $urandom;
            rsv_en   = ($urandom_range(0, 3) == 0);
            rsv_addr = ($urandom_range(0, 1) == 0) ? wa : AWL'($urandom_range(0, 7));
            for (int i = 0; i < NRP; i++) begin
                ra_bus[i*AWL +: AWL] = ($urandom_range(0, 2) == 0) ? wa : AWL'($urandom_range(0, DEPTH - 1));
            end
            tick();
        end

        // Mid-operation reset with register 3 pending and holding data.
        idle();
        wen = 1'b1; wa = 5'd3; wd = 32'hAB;
        tick();
        idle(); rsv_en = 1'b1; rsv_addr = 5'd3;
        tick();
        idle(); set_ra(3, 3, 3);
        #1;
        chk("pre_rst_busy", 32'(busy1[0]), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_ready", 32'(ready0), 32'd0);
        chk("rst_rd_sync", sl(rd1, 0), '0);
        rst_n = 1'b1;
        wait_ready(n);
        chk("reclear_len", 32'(n), 32'd31);
        #1;
        chk("reclear_rd3", sl(rd0, 0), '0);
        tick();
        chk("reclear_rd3_sync", sl(rd2, 0), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multiport_regfile.md
MIPS_MULTIPORT_REGFILE -- requirements
Module: mips_multiport_regfile

Interface
REQ-001 SHALL have parameter AWL, default 5, address word length.
REQ-002 SHALL have parameter DWL, default 32, data word length.
REQ-003 SHALL have parameter NRP, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter MODE, default 0, read mode: 0 async read, 1 write first, 2 read first.
REQ-005 SHALL have parameter BYPASS, default 1, which enables write-to-read forwarding in MODE 0.
REQ-006 SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port wen, input, 1 bit: write enable.
REQ-009 SHALL have port WA, input, AWL bits: write address.
REQ-010 SHALL have port WD, input, DWL bits: write data.
REQ-011 SHALL have port RA, input, NRP*AWL bits: read addresses, with port i at bits [i*AWL +: AWL].
REQ-012 SHALL have port RD, output, NRP*DWL bits: read data, with port i at bits [i*DWL +: DWL].
REQ-013 SHALL have port rsv_en, input, 1 bit: reserve the destination register of an issued instruction.
REQ-014 SHALL have port rsv_addr, input, AWL bits: register to reserve.
REQ-015 SHALL have port busy, output, NRP bits: busy[i] is high when register RA[i] has a pending write.
REQ-016 SHALL have port ready, output, 1 bit: high when initialisation is complete and the block accepts operations.

Function
REQ-017 SHALL implement a two-state FSM with states CLEAR and READY.
REQ-018 In CLEAR, SHALL write 0 to entry clr_ptr each cycle and increment clr_ptr; clr_ptr starts at 1.
REQ-019 SHALL go from CLEAR to READY in the cycle after entry 2**AWL-1 is cleared, so CLEAR lasts 2**AWL-1 cycles.
REQ-020 ready SHALL be 1 only in READY.
REQ-021 In CLEAR, SHALL ignore wen and rsv_en, and SHALL drive busy to all zeros.
REQ-022 Register 0 SHALL always read as 0; writes and reservations to address 0 SHALL be discarded.
REQ-023 In READY, when wen=1 and WA!=0, SHALL store WD into entry WA at the clock edge.
REQ-024 In MODE 0, RD[i] SHALL combinationally equal entry RA[i].
- Exception, when BYPASS=1: if wen=1, WA=RA[i] and WA!=0, RD[i] SHALL equal WD in the same cycle.
REQ-025 In MODE 1, RD[i] SHALL be valid one cycle after RA[i] is presented.
- If the same entry is written in that cycle, RD[i] SHALL show the new WD.
REQ-026 In MODE 2, RD[i] SHALL be registered, one-cycle latency.
- If the same entry is written in that cycle, RD[i] SHALL show the pre-write value.
REQ-027 SHALL keep a pending bit per register.
- rsv_en=1 with rsv_addr!=0 sets pending[rsv_addr] at the clock edge.
- wen=1 clears pending[WA] at the clock edge.
REQ-028 If rsv_en and wen target the same nonzero address in one cycle, set SHALL win and pending stays 1.
REQ-029 busy[i] SHALL combinationally equal pending[RA[i]], and SHALL be 0 for RA[i]=0.
- Under BYPASS=1 in MODE 0, busy[i] SHALL be 0 when wen=1 and WA=RA[i].
REQ-030 Read ports SHALL be independent; all NRP ports reading one address SHALL return identical data.

Reset
REQ-031 When rst_n=0 at a clock edge, the block SHALL enter CLEAR, set clr_ptr=1, clear all pending bits, and set ready=0.
REQ-032 On that same reset edge, registered RD outputs (MODE 1 and MODE 2) SHALL go to 0.
REQ-033 Reset asserted during CLEAR or READY SHALL restart the full clear sequence.
- Register contents after reset SHALL be 0 once ready rises.

Structure
REQ-034 Package mips_rf_pkg SHALL hold:
- the rf_mode_t enum (ASYNC=0, WFIRST=1, RFIRST=2);
- the rf_state_t enum (CLEAR, READY).
REQ-035 The pending-bit logic SHALL be the sub-module mips_rf_scoreboard, parameterised by AWL and NRP.
REQ-036 Read ports SHALL be built with a generate loop over NRP.

Verification (AWL=5, DWL=32, NRP=3)
REQ-037 Scenario 1 (clear and fill):
- Pulse rst_n low for 1 cycle -> ready=0 for 31 cycles, then 1.
- Reading all 32 addresses then returns 0.
REQ-038 Scenario 2 (MODE 0, BYPASS=1):
- Stimulus: wen=1, WA=7, WD=0xDEADBEEF, RA[0]=7 in the same cycle.
- Response: RD[0]=0xDEADBEEF in that cycle, and RD[1]=0xDEADBEEF when reading 7 on the next cycle.
REQ-039 Scenario 3 (write to zero):
- Stimulus: write 0x12345678 to WA=0.
- Response: every port reading address 0 returns 0.
REQ-040 Scenario 4 (MODE 1 and MODE 2 collision):
- Setup: entry 5 holds 0x11.
- Stimulus: write 0x22 to entry 5 while RA[0]=5.
- Response: next cycle MODE 1 gives RD[0]=0x22; MODE 2 gives RD[0]=0x11.
REQ-041 Scenario 5 (scoreboard):
- rsv_en with rsv_addr=9 -> busy[2]=1 for RA[2]=9.
- Then wen=1 and rsv_en in one cycle, both to 9 -> busy stays 1.
- Then wen alone to 9 -> busy[2]=0 next cycle.
REQ-042 Scenario 6 (mid-operation reset):
- Stimulus: rst_n=0 while pending[3]=1 and entry 3 holds 0xAB.
- Response: busy=0 and ready=0 immediately; after ready rises, entry 3 reads 0.
